// File: rtl/div_result_collector.sv
// Purpose: collects quotient/remainder results from a fixed-latency, non-stallable divider into a result FIFO.
// Latency: a result is visible on res_valid LATENCY cycles after the fire edge, when the FIFO was empty.
// Backpressure: issue_ready grants one credit per free FIFO slot, so res_ready stalls upstream issue, never the divider.
module div_result_collector #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2 * WIDTH,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [WIDTH-1:0]         issue_divisor,
    input  logic [2*WIDTH-1:0]       div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_quotient,
    output logic [WIDTH-1:0]         res_remainder,
    output logic                     res_div_zero,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY-1:0]   r_vld_pipe;
    logic [LATENCY-1:0]   r_zero_pipe;
    logic [2*WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]     r_mem_r [DEPTH];
    logic                 r_mem_z [DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [CW-1:0]        r_outstanding;
    logic                 r_err_overflow;

    logic                 w_fire;
    logic                 w_pop;
    logic                 w_cap;
    logic                 w_cap_zero;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic [2*WIDTH-1:0]   w_cap_q;
    logic [WIDTH-1:0]     w_cap_r;

    assign issue_ready = (r_outstanding < CW'(DEPTH));
    assign w_fire      = issue_valid & issue_ready;

    // Extra wrap bit distinguishes full (same index, different lap) from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign res_valid = ~w_empty;
    assign w_pop     = res_valid & res_ready;

    assign w_cap      = r_vld_pipe[LATENCY-1];
    assign w_cap_zero = r_zero_pipe[LATENCY-1];
    assign w_wr       = w_cap & ~w_full;
    assign w_cap_q    = w_cap_zero ? '1 : div_quotient;
    assign w_cap_r    = w_cap_zero ? '0 : div_remainder;

    assign res_quotient  = r_mem_q[r_rd_ptr[AW-1:0]];
    assign res_remainder = r_mem_r[r_rd_ptr[AW-1:0]];
    assign res_div_zero  = r_mem_z[r_rd_ptr[AW-1:0]];
    assign outstanding   = r_outstanding;
    assign err_overflow  = r_err_overflow;

    // Shadow of the divider pipeline: which slots hold real operations and which had a zero divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_zero_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_fire;
            r_zero_pipe[0] <= w_fire && (issue_divisor == '0);
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_zero_pipe[i] <= r_zero_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_outstanding  <= '0;
            r_err_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
                r_mem_r[i] <= '0;
                r_mem_z[i] <= 1'b0;
            end
        end else begin
            if (w_wr) begin
                r_mem_q[r_wr_ptr[AW-1:0]] <= w_cap_q;
                r_mem_r[r_wr_ptr[AW-1:0]] <= w_cap_r;
                r_mem_z[r_wr_ptr[AW-1:0]] <= w_cap_zero;
                r_wr_ptr                  <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_cap && w_full) begin
                r_err_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
